// File: rtl/spi_master_sched.sv
// Two-requester SPI Mode 0 master that arbitrates, sends a 16-bit {rw, addr, data} frame and returns read data.
// Define SPI_SCHED_RR_EN for round-robin arbitration; by default requester 0 has fixed priority.
module spi_master_sched #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_rw,
  input  logic [13:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        busy,
  output logic        cs_n,
  output logic        sck,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [1:0] {IDLE, GRANT, SHIFT, GAP} state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    half_q, half_d;
  logic [15:0]   frame_q, frame_d;
  logic          idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rise_q, rise_d;
  logic          cs_n_q, cs_n_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
`ifdef SPI_SCHED_RR_EN
  logic          last_q, last_d;
`endif

  logic [1:0]  grant_s;
  logic        win_s;
  logic        new_rw_s;
  logic [6:0]  new_addr_s;
  logic [7:0]  new_wdata_s;
  logic [15:0] new_frame_s;

  // Arbitration is only live in IDLE and never during reset.
  always_comb begin
    grant_s = 2'b00;
    if (state_q == IDLE && !rst) begin
`ifdef SPI_SCHED_RR_EN
      if (req_valid == 2'b11) grant_s = last_q ? 2'b01 : 2'b10;
      else                    grant_s = req_valid;
`else
      if (req_valid[0])       grant_s = 2'b01;
      else if (req_valid[1])  grant_s = 2'b10;
      else                    grant_s = 2'b00;
`endif
    end
    win_s       = grant_s[1];
    new_rw_s    = req_rw[win_s];
    new_addr_s  = win_s ? req_addr[13:7]  : req_addr[6:0];
    new_wdata_s = win_s ? req_wdata[15:8] : req_wdata[7:0];
    new_frame_s = {new_rw_s, new_addr_s, new_rw_s ? 8'h00 : new_wdata_s};
  end

  // half_d counts SCK half-periods since cs_n fell: odd = rising, even = falling, 32 = end of frame.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    half_d      = half_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rise_d      = 1'b0;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
`ifdef SPI_SCHED_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          state_d = GRANT;
          frame_d = new_frame_s;
          idx_d   = win_s;
          cs_n_d  = 1'b0;
          mosi_d  = new_frame_s[15];
          div_d   = '0;
          half_d  = 6'd0;
`ifdef SPI_SCHED_RR_EN
          last_d  = win_s;
`endif
        end
      end
      GRANT, SHIFT: begin
        state_d = SHIFT;
        // miso is captured at the end of the first SCK-high cycle.
        if (rise_q) shift_d = {shift_q[6:0], miso};
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          half_d = half_q + 6'd1;
          if (half_d[0]) begin
            sck_d  = 1'b1;
            rise_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (half_d == 6'd32) begin
              cs_n_d      = 1'b1;
              mosi_d      = 1'b0;
              rsp_valid_d = idx_q ? 2'b10 : 2'b01;
              rsp_rdata_d = frame_q[15] ? shift_d : 8'h00;
              state_d     = GAP;
            end else begin
              mosi_d = frame_q[4'd15 - half_d[4:1]];
            end
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      GAP: begin
        if (div_q == DIV_LAST) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      half_q      <= 6'd0;
      frame_q     <= 16'h0000;
      idx_q       <= 1'b0;
      shift_q     <= 8'h00;
      rise_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= 8'h00;
`ifdef SPI_SCHED_RR_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      half_q      <= half_d;
      frame_q     <= frame_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rise_q      <= rise_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef SPI_SCHED_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign req_ready = grant_s;
  assign busy      = (state_q != IDLE) || (grant_s != 2'b00);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign cs_n      = cs_n_q;
  assign sck       = sck_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Self-checking bench for spi_master_sched: timing model from cs_n-fall offsets plus directed literal checks.
module tb_spi_master_sched;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_rw = 2'b00;
  logic [13:0] req_addr = 14'd0;
  logic [15:0] req_wdata = 16'd0;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        busy, cs_n, sck, mosi;
  logic        miso = 1'b0;

  spi_master_sched #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .cs_n(cs_n), .sck(sck), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic chk_en = 1'b0;
  logic [15:0] slave_word = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  // Reference model state: a transaction is fully described by its cs_n-fall cycle and frame.
  logic        m_busy = 1'b0;
  int          m_t = 0;
  logic        m_idx = 1'b0;
  logic        m_last = 1'b1;
  logic        m_rw = 1'b0;
  logic [15:0] m_frame = 16'h0;
  logic [15:0] m_word = 16'h0;
  logic        w;
  int          o;
  logic [1:0]  e_rdy, e_rv;
  logic        e_cs, e_sck, e_mosi, e_busy;
  // Monitor bookkeeping used by the directed tests.
  logic        p_sck = 1'b0, p_cs = 1'b1, p_mosi = 1'b0, p_rst = 1'b1, seen_fall = 1'b0;
  logic        mosi_ok;
  int          rises = 0, cs_low = 0, rsp_cnt = 0, hi_run = 0;
  logic [15:0] mosi_cap = 16'h0;
  logic [1:0]  last_rv = 2'b00;
  logic [7:0]  last_rdata = 8'h00;
  logic        grant_q[$];
  int          gap_q[$];

  always @(negedge clk) begin
    e_rdy = 2'b00; e_rv = 2'b00; e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_busy = 1'b0;
    if (m_busy) begin
      e_busy = 1'b1;
      o = cyc - m_t;
      if (o < 32 * D) begin
        e_cs   = 1'b0;
        e_sck  = ((o / D) % 2) == 1;
        e_mosi = m_frame[15 - o / (2 * D)];
      end else if (o == 32 * D) begin
        e_rv = m_idx ? 2'b10 : 2'b01;
      end
    end else if (!rst && req_valid != 2'b00) begin
`ifdef SPI_SCHED_RR_EN
      if (req_valid == 2'b11) w = ~m_last;
      else                    w = req_valid[1];
`else
      w = ~req_valid[0];
`endif
      e_rdy   = w ? 2'b10 : 2'b01;
      e_busy  = 1'b1;
      m_busy  = 1'b1;
      m_t     = cyc + 1;
      m_idx   = w;
      m_last  = w;
      m_rw    = req_rw[w];
      m_frame = {m_rw, req_addr[w*7 +: 7], m_rw ? 8'h00 : req_wdata[w*8 +: 8]};
      m_word  = slave_word;
    end
    if (chk_en) begin
      chk("req_ready", 16'(req_ready), 16'(e_rdy));
      chk("busy", 16'(busy), 16'(e_busy));
      chk("cs_n", 16'(cs_n), 16'(e_cs));
      chk("sck", 16'(sck), 16'(e_sck));
      chk("mosi", 16'(mosi), 16'(e_mosi));
      chk("rsp_valid", 16'(rsp_valid), 16'(e_rv));
      if (e_rv != 2'b00) chk("rsp_rdata", 16'(rsp_rdata), 16'(m_rw ? m_word[7:0] : 8'h00));
      chk("sck_while_cs_high", 16'(sck & cs_n), 16'd0);
      mosi_ok = (mosi === p_mosi) || (p_sck && !sck) || (p_cs && !cs_n) || p_rst;
      chk("mosi_stable", 16'(mosi_ok), 16'd1);
    end
    if (m_busy && (cyc - m_t) == 33 * D - 1) m_busy = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_last = 1'b1;
    end
    // Slave: present bit k of the word for the whole k-th SCK period.
    if (m_busy && cyc >= m_t && (cyc - m_t) < 32 * D) miso = m_word[15 - (cyc - m_t) / (2 * D)];
    else miso = 1'b0;
    if (sck && !p_sck) begin
      rises++;
      mosi_cap = {mosi_cap[14:0], mosi};
    end
    if (!cs_n) cs_low++;
    if (rsp_valid != 2'b00) begin
      rsp_cnt++;
      last_rv = rsp_valid;
      last_rdata = rsp_rdata;
    end
    if (req_ready != 2'b00) grant_q.push_back(req_ready[1]);
    if (cs_n) hi_run++;
    else begin
      if (p_cs && seen_fall) gap_q.push_back(hi_run);
      seen_fall = 1'b1;
      hi_run = 0;
    end
    p_sck = sck; p_cs = cs_n; p_mosi = mosi; p_rst = rst;
  end

  task automatic do_txn(input int i, input logic rw, input logic [6:0] a, input logic [7:0] wd,
                        input logic [15:0] sw);
    int n;
    slave_word = sw;
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_rw[i] = rw;
    req_addr[i*7 +: 7] = a;
    req_wdata[i*8 +: 8] = wd;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (req_ready[i]) break;
      n++;
    end
    chk("grant_timeout", 16'(n < 40), 16'd1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n = 0;
    while (n < 40 * D) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) break;
      n++;
    end
    chk("rsp_timeout", 16'(n < 40 * D), 16'd1);
    @(posedge clk); #1;
  endtask

  int r0, c0, q0, g0, rs0, cnt, n, nr;
  logic pr;
  logic [1:0] hs;
  logic [31:0] rnd;
  logic [2:0] ord, exp_ord;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", 16'(cs_n), 16'd1);
    chk("rst_sck", 16'(sck), 16'd0);
    chk("rst_mosi", 16'(mosi), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_rdata", 16'(rsp_rdata), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Write: req0, addr 12, data A5.
    r0 = rises; c0 = cs_low;
    do_txn(0, 1'b0, 7'h12, 8'hA5, 16'hFFFF);
    chk("wr_mosi_frame", mosi_cap, 16'h12A5);
    chk("wr_sck_rises", 16'(rises - r0), 16'd16);
    chk("wr_cs_low_cycles", 16'(cs_low - c0), 16'(32 * D));
    chk("wr_rsp_valid", 16'(last_rv), 16'h0001);
    chk("wr_rsp_rdata", 16'(last_rdata), 16'h0000);

    // Read: req1, addr 05, slave returns 3C in the data byte.
    r0 = rises;
    do_txn(1, 1'b1, 7'h05, 8'hEE, 16'h963C);
    chk("rd_addr_byte", 16'(mosi_cap[15:8]), 16'h0085);
    chk("rd_data_byte", 16'(mosi_cap[7:0]), 16'h0000);
    chk("rd_sck_rises", 16'(rises - r0), 16'd16);
    chk("rd_rsp_valid", 16'(last_rv), 16'h0002);
    chk("rd_rsp_rdata", 16'(last_rdata), 16'h003C);

    // Both requesters held for three back-to-back transactions.
    g0 = grant_q.size(); q0 = gap_q.size();
    @(posedge clk); #1;
    req_valid = 2'b11; req_rw = 2'b00; req_addr = 14'h1234; req_wdata = 16'h5AC3;
    cnt = 0; n = 0;
    while (cnt < 3 && n < 200 * D) begin
      @(negedge clk);
      if (req_ready != 2'b00) cnt++;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("sim_grants", 16'(cnt), 16'd3);
    repeat (40 * D) @(posedge clk);
    if (grant_q.size() >= g0 + 3 && gap_q.size() >= q0 + 3) begin
      ord = {grant_q[g0], grant_q[g0 + 1], grant_q[g0 + 2]};
`ifdef SPI_SCHED_RR_EN
      exp_ord = 3'b010;
`else
      exp_ord = 3'b000;
`endif
      chk("sim_order", 16'(ord), 16'(exp_ord));
      chk("sim_gap1", 16'(gap_q[q0 + 1]), 16'(D + 1));
      chk("sim_gap2", 16'(gap_q[q0 + 2]), 16'(D + 1));
    end else begin
      chk("sim_log_size", 16'(grant_q.size() - g0), 16'd3);
    end

    // Reset at the 9th SCK rise aborts without a response.
    slave_word = 16'h0000;
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_rw[0] = 1'b0; req_addr[6:0] = 7'h33; req_wdata[7:0] = 8'h5A;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (req_ready[0]) break;
      n++;
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rs0 = rsp_cnt; pr = sck; nr = 0; n = 0;
    while (nr < 9 && n < 40 * D) begin
      @(posedge clk); #1;
      if (sck && !pr) nr++;
      pr = sck;
      n++;
    end
    chk("rst_at_rise9", 16'(nr), 16'd9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", 16'(cs_n), 16'd1);
    chk("abort_sck", 16'(sck), 16'd0);
    repeat (40 * D) @(posedge clk);
    chk("abort_no_rsp", 16'(rsp_cnt - rs0), 16'd0);
    do_txn(0, 1'b1, 7'h7F, 8'h00, 16'h1296);
    chk("post_rst_rsp_valid", 16'(last_rv), 16'h0001);
    chk("post_rst_rdata", 16'(last_rdata), 16'h0096);
    chk("post_rst_frame", mosi_cap, 16'hFF00);

    // Random traffic: hold fields while waiting, occasionally withdraw.
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk); #1;
      slave_word = 16'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (hs[i] || !req_valid[i]) begin
          rnd = $urandom;
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_rw[i] = rnd[0];
          req_addr[i*7 +: 7] = rnd[7:1];
          req_wdata[i*8 +: 8] = rnd[15:8];
        end else if ($urandom_range(0, 49) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    req_valid = 2'b00;
    repeat (40 * D) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
